// File: rtl/rams128_byte_port_pkg.sv
// Shared constants and FSM state type for the byte-wide front end of a 128x1 distributed RAM.
// No ports: package only.
package rams128_byte_port_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned BIT_IDX_W = 3;
    localparam int unsigned RAM_ADR_W = 7;
    localparam int unsigned RAM_DEPTH = 128;

    typedef enum logic [2:0] {
        INIT,
        SCRUB,
        IDLE,
        WR,
        RD
    } state_e;

endpackage

// File: rtl/rams128_byte_port_if.sv
// Request/response bus of rams128_byte_port.
//   REQ_VALID/REQ_READY : request handshake, taken on a rising edge with both high
//   REQ_WE              : 1 = write byte, 0 = read byte
//   REQ_ADDR            : byte address 0..15
//   REQ_WDATA           : write data (ignored for reads)
//   RSP_VALID           : one-cycle pulse, RSP_RDATA carries a completed read
//   RSP_RDATA           : last read result, held until the next read completes
// master = requester, slave = rams128_byte_port.
interface rams128_byte_port_if;
    import rams128_byte_port_pkg::*;

    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [BYTE_W-1:0] REQ_WDATA;
    logic              RSP_VALID;
    logic [BYTE_W-1:0] RSP_RDATA;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
        output REQ_READY, RSP_VALID, RSP_RDATA
    );

endinterface

// File: rtl/rams128_byte_port.sv
// Byte-wide request/response front end for a 128x1 single-port RAM (X_RAMS128).
// Each byte request becomes eight single-bit accesses, LSB first; bit b of byte A lives at
// RAM address {A, b}. Optional zero-fill of all 128 bits after reset.
// Ports:
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : request/response interface (slave side)
//   RAM_ADR    : RAM address (ADR6..ADR0)
//   RAM_I      : RAM data in
//   RAM_WE     : RAM write enable (RAM writes on the same rising edge)
//   RAM_O      : RAM combinational read output for RAM_ADR
module rams128_byte_port
    import rams128_byte_port_pkg::*;
#(
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    rams128_byte_port_if.slave   bus,
    output logic [RAM_ADR_W-1:0] RAM_ADR,
    output logic                 RAM_I,
    output logic                 RAM_WE,
    input  logic                 RAM_O
);

    state_e                 state_q, state_d;
    // Scrub address in SCRUB; the low bits double as the bit index in WR/RD.
    logic [RAM_ADR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [BYTE_W-1:0]      wdata_q, wdata_d;
    // Bits 0..6 of a read in flight; bit 7 goes straight into the response.
    logic [BYTE_W-2:0]      shift_q, shift_d;
    logic [BYTE_W-1:0]      rdata_q, rdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   ready_q, ready_d;
    logic [RAM_ADR_W-1:0]   ram_adr_q, ram_adr_d;
    logic                   ram_i_q, ram_i_d;
    logic                   ram_we_q, ram_we_d;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [BIT_IDX_W-1:0]   bit_idx_d;

    assign bit_idx   = cnt_q[BIT_IDX_W-1:0];
    assign bit_idx_d = cnt_d[BIT_IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            INIT: begin
                cnt_d   = '0;
                state_d = SCRUB_EN ? SCRUB : IDLE;
            end
            SCRUB: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RAM_ADR_W'(RAM_DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.REQ_VALID) begin
                    addr_d  = bus.REQ_ADDR;
                    wdata_d = bus.REQ_WDATA;
                    cnt_d   = '0;
                    state_d = bus.REQ_WE ? WR : RD;
                end
            end
            WR: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_idx == 3'd7) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_idx == 3'd7) begin
                    rdata_d     = {RAM_O, shift_q};
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    shift_d[bit_idx] = RAM_O;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it, so the RAM side
    // never sees a combinational path from the request bus.
    always_comb begin
        ready_d   = (state_d == IDLE);
        ram_adr_d = '0;
        ram_i_d   = 1'b0;
        ram_we_d  = 1'b0;
        case (state_d)
            SCRUB: begin
                ram_adr_d = cnt_d;
                ram_we_d  = 1'b1;
            end
            WR: begin
                ram_adr_d = {addr_d, bit_idx_d};
                ram_i_d   = wdata_d[bit_idx_d];
                ram_we_d  = 1'b1;
            end
            RD: begin
                ram_adr_d = {addr_d, bit_idx_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            ram_adr_q   <= '0;
            ram_i_q     <= 1'b0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            ram_adr_q   <= ram_adr_d;
            ram_i_q     <= ram_i_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign bus.REQ_READY = ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rdata_q;
    assign RAM_ADR       = ram_adr_q;
    assign RAM_I         = ram_i_q;
    assign RAM_WE        = ram_we_q;

endmodule

// File: tb/tb_rams128_byte_port.sv
// Bench for rams128_byte_port: instance 1 (scrub enabled) exercises scrub, directed and random
// byte traffic against a byte-array model; instance 2 (scrub disabled) covers reset mid-write.
// Both RAMs are 128x1 arrays written on the rising edge with a combinational read.
module tb_rams128_byte_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rsp = 0;
    string step  = "reset";

    logic rst1_n, rst2_n;
    rams128_byte_port_if bus1 ();
    rams128_byte_port_if bus2 ();
    logic [6:0] adr1, adr2;
    logic       i1, i2, we1, we2, o1, o2;

    rams128_byte_port #(.SCRUB_EN(1'b1)) dut1 (
        .CLK    (clk),
        .RST_N  (rst1_n),
        .bus    (bus1),
        .RAM_ADR(adr1),
        .RAM_I  (i1),
        .RAM_WE (we1),
        .RAM_O  (o1)
    );

    rams128_byte_port #(.SCRUB_EN(1'b0)) dut2 (
        .CLK    (clk),
        .RST_N  (rst2_n),
        .bus    (bus2),
        .RAM_ADR(adr2),
        .RAM_I  (i2),
        .RAM_WE (we2),
        .RAM_O  (o2)
    );

    // X_RAMS128 stand-ins; RAM 1 starts with garbage so the scrub is observable.
    logic [127:0] mem1, mem2, seed1;
    logic         load;
    always @(posedge clk) begin
        if (load) begin
            mem1 <= seed1;
            mem2 <= '0;
        end else begin
            if (we1) mem1[adr1] <= i1;
            if (we2) mem2[adr2] <= i2;
        end
    end
    assign o1 = mem1[adr1];
    assign o2 = mem2[adr2];

    // Reference: byte contents as seen through the request interface.
    logic [7:0] model [16];
    logic [7:0] last_rd = 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (bus1.REQ_READY !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(bus1.REQ_READY), 32'd1);
    endtask

    // One byte request on instance 1, starting with READY high and ending in cycle 9.
    task automatic do_req(input bit we, input logic [3:0] a, input logic [7:0] wd);
        wait_ready1();
        bus1.REQ_VALID = 1'b1;
        bus1.REQ_WE    = we;
        bus1.REQ_ADDR  = a;
        bus1.REQ_WDATA = wd;
        tick();
        for (int b = 0; b < 8; b++) begin
            // Noise on the request bus while busy must not be taken.
            bus1.REQ_VALID = 1'($urandom_range(0, 1));
            bus1.REQ_WE    = 1'($urandom_range(0, 1));
            bus1.REQ_ADDR  = 4'($urandom);
            bus1.REQ_WDATA = 8'($urandom);
            chk("ram_adr", 32'(adr1), 32'({a, 3'(b)}));
            chk("ram_we", 32'(we1), 32'(we));
            if (we) chk("ram_i", 32'(i1), 32'(wd[b]));
            chk("busy_ready", 32'(bus1.REQ_READY), 32'd0);
            chk("busy_rsp", 32'(bus1.RSP_VALID), 32'd0);
            tick();
        end
        bus1.REQ_VALID = 1'b0;
        chk("done_ready", 32'(bus1.REQ_READY), 32'd1);
        chk("done_we", 32'(we1), 32'd0);
        if (we) begin
            chk("wr_no_rsp", 32'(bus1.RSP_VALID), 32'd0);
            chk("rdata_hold", 32'(bus1.RSP_RDATA), 32'(last_rd));
            model[a] = wd;
        end else begin
            chk("rsp_valid", 32'(bus1.RSP_VALID), 32'd1);
            chk("rdata", 32'(bus1.RSP_RDATA), 32'(model[a]));
            last_rd  = model[a];
            last_rsp = cyc;
        end
    endtask

    initial begin
        int t1;
        load           = 1'b1;
        seed1          = {$urandom, $urandom, $urandom, $urandom};
        rst1_n         = 1'b0;
        rst2_n         = 1'b0;
        bus1.REQ_VALID = 1'b0;
        bus1.REQ_WE    = 1'b0;
        bus1.REQ_ADDR  = '0;
        bus1.REQ_WDATA = '0;
        bus2.REQ_VALID = 1'b0;
        bus2.REQ_WE    = 1'b0;
        bus2.REQ_ADDR  = '0;
        bus2.REQ_WDATA = '0;
        tick();
        tick();
        tick();
        load = 1'b0;

        chk("rst_ready", 32'(bus1.REQ_READY), 32'd0);
        chk("rst_rsp", 32'(bus1.RSP_VALID), 32'd0);
        chk("rst_rdata", 32'(bus1.RSP_RDATA), 32'd0);
        chk("rst_adr", 32'(adr1), 32'd0);
        chk("rst_i", 32'(i1), 32'd0);
        chk("rst_we", 32'(we1), 32'd0);
        chk("rst2_ready", 32'(bus2.REQ_READY), 32'd0);

        // Release with a read of address 5 already pending; INIT + 128 scrub cycles follow.
        step           = "scrub";
        bus1.REQ_VALID = 1'b1;
        bus1.REQ_WE    = 1'b0;
        bus1.REQ_ADDR  = 4'd5;
        rst1_n         = 1'b1;
        chk("init_ready", 32'(bus1.REQ_READY), 32'd0);
        chk("init_we", 32'(we1), 32'd0);
        for (int i = 1; i <= 128; i++) begin
            tick();
            chk("scrub_ready", 32'(bus1.REQ_READY), 32'd0);
            chk("scrub_we", 32'(we1), 32'd1);
            chk("scrub_adr", 32'(adr1), 32'(i - 1));
            chk("scrub_i", 32'(i1), 32'd0);
        end
        tick();
        chk("first_ready", 32'(bus1.REQ_READY), 32'd1);
        for (int a = 0; a < 16; a++) model[a] = 8'h00;
        do_req(1'b0, 4'd5, 8'h00);

        step = "zero";
        for (int a = 0; a < 16; a++) do_req(1'b0, 4'(a), 8'h00);

        step = "a5";
        do_req(1'b1, 4'h3, 8'hA5);
        do_req(1'b0, 4'h3, 8'h00);
        chk("rdata_a5", 32'(bus1.RSP_RDATA), 32'hA5);

        step = "fill";
        for (int a = 0; a < 16; a++) do_req(1'b1, 4'(a), {4'(a), ~4'(a)});
        for (int a = 15; a >= 0; a--) do_req(1'b0, 4'(a), 8'h00);

        // Second request is taken in the RSP_VALID cycle of the first.
        step = "b2b";
        do_req(1'b0, 4'd2, 8'h00);
        t1 = last_rsp;
        do_req(1'b0, 4'd9, 8'h00);
        chk("rsp_spacing", 32'(last_rsp - t1), 32'd9);

        step = "rand";
        for (int n = 0; n < 48; n++) begin
            do_req(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
        end
        for (int a = 0; a < 16; a++) do_req(1'b0, 4'(a), 8'h00);

        // Instance 2: reset lands on the edge that commits bit 2 of an 8'hFF write to byte 7.
        step   = "rst_mid";
        rst2_n = 1'b1;
        tick();
        chk("noscrub_ready", 32'(bus2.REQ_READY), 32'd1);
        chk("noscrub_we", 32'(we2), 32'd0);
        bus2.REQ_VALID = 1'b1;
        bus2.REQ_WE    = 1'b1;
        bus2.REQ_ADDR  = 4'd7;
        bus2.REQ_WDATA = 8'hFF;
        tick();
        bus2.REQ_VALID = 1'b0;
        tick();
        tick();
        chk("wr_adr_b2", 32'(adr2), 32'h3A);
        chk("wr_we_b2", 32'(we2), 32'd1);
        rst2_n = 1'b0;
        tick();
        chk("abort_ready", 32'(bus2.REQ_READY), 32'd0);
        chk("abort_we", 32'(we2), 32'd0);
        chk("abort_adr", 32'(adr2), 32'd0);
        chk("abort_i", 32'(i2), 32'd0);
        chk("abort_rsp", 32'(bus2.RSP_VALID), 32'd0);
        chk("abort_rdata", 32'(bus2.RSP_RDATA), 32'd0);
        tick();
        rst2_n = 1'b1;
        tick();
        chk("rerelease_ready", 32'(bus2.REQ_READY), 32'd1);
        bus2.REQ_VALID = 1'b1;
        bus2.REQ_WE    = 1'b0;
        bus2.REQ_ADDR  = 4'd7;
        tick();
        bus2.REQ_VALID = 1'b0;
        for (int b = 0; b < 8; b++) begin
            chk("rd2_busy_rsp", 32'(bus2.RSP_VALID), 32'd0);
            tick();
        end
        chk("rd2_rsp", 32'(bus2.RSP_VALID), 32'd1);
        chk("rd2_rdata", 32'(bus2.RSP_RDATA), 32'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
